// File: rtl/token_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : token_dispatcher_if
// Description : Token stream and configuration bundle for token_dispatcher.
//               The master side is the token source plus the configuring
//               controller. The slave side is the dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
interface token_dispatcher_if #(
  parameter int N_OUT = 4,
  parameter int W_W   = 4
);
  logic             a;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [N_OUT-1:0] cfg_mask;
  logic [W_W-1:0]   cfg_weight;
  logic [N_OUT-1:0] b;
  logic             drop;

  modport master (
    output a, cfg_valid, cfg_mask, cfg_weight,
    input  cfg_ready, b, drop
  );

  modport slave (
    input  a, cfg_valid, cfg_mask, cfg_weight,
    output cfg_ready, b, drop
  );
endinterface
`default_nettype wire

// File: rtl/token_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : token_dispatcher
// Description : Weighted round-robin distribution of a one-cycle token
//               stream across N_OUT lanes. The lane mask and the weight are
//               runtime-programmable over a valid/ready config port.
//               Optional macro TOKEN_DISPATCHER_STATS_EN adds a saturating
//               drop counter (drop_cnt) and its clear input (stats_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module token_dispatcher #(
  parameter int N_OUT = 4,
  parameter int W_W   = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
`ifdef TOKEN_DISPATCHER_STATS_EN
  input  wire logic         stats_clr,
  output logic [15:0]       drop_cnt,
`endif
  token_dispatcher_if.slave bus
);

  localparam int              PTR_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned     N_U   = N_OUT;
  localparam logic [W_W-1:0]  W_ONE = W_W'(1);
  localparam logic [N_OUT-1:0] LANE0 = {{(N_OUT-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [N_OUT-1:0] mask_q;
  logic [W_W-1:0]   weight_q;
  logic [PTR_W-1:0] ptr_q;
  logic [W_W-1:0]   cnt_q;
  logic [N_OUT-1:0] b_q;
  logic             drop_q;

  logic [PTR_W-1:0] rot_ptr_d;
  logic [PTR_W-1:0] first_ptr_d;

  // Config is only accepted outside token cycles, so a token and a config
  // accept can never land on the same edge.
  assign bus.cfg_ready = ~bus.a;
  assign bus.b         = b_q;
  assign bus.drop      = drop_q;

  // Next enabled lane above ptr, wrapping. The scan runs from the farthest
  // offset to the nearest, so the nearest hit is the one that wins. With a
  // single enabled lane there is no hit and ptr stays where it is.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    rot_ptr_d = ptr_q;
    for (int unsigned i = N_U - 1; i >= 1; i--) begin
      idx = 32'(ptr_q) + i;
      if (idx >= N_U) idx = idx - N_U;
      if (mask_q[idx[PTR_W-1:0]]) rot_ptr_d = idx[PTR_W-1:0];
    end
  end

  // Lowest set bit of the incoming mask. This is the lane where the
  // rotation restarts after a config accept.
  always_comb begin
    first_ptr_d = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (bus.cfg_mask[i]) first_ptr_d = PTR_W'(i);
    end
  end

  // Control FSM, dispatch, and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      weight_q <= W_ONE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      drop_q   <= 1'b0;
    end else begin
      b_q    <= '0;
      drop_q <= 1'b0;
      if (bus.a) begin
        if (state_q == RUN) begin
          b_q <= LANE0 << ptr_q;
          if (cnt_q == weight_q - W_ONE) begin
            cnt_q <= '0;
            ptr_q <= rot_ptr_d;
          end else begin
            cnt_q <= cnt_q + W_ONE;
          end
        end else begin
          drop_q <= 1'b1;
        end
      end else if (bus.cfg_valid) begin
        mask_q   <= bus.cfg_mask;
        weight_q <= (bus.cfg_weight == '0) ? W_ONE : bus.cfg_weight;
        ptr_q    <= first_ptr_d;
        cnt_q    <= '0;
        state_q  <= (bus.cfg_mask != '0) ? RUN : IDLE;
      end
    end
  end

`ifdef TOKEN_DISPATCHER_STATS_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of drop pulses. A clear takes priority over a
  // same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      drop_cnt_q <= '0;
    end else if (drop_q && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/token_dispatcher.md
Name: token_dispatcher

Overview:
- Distributes a serial token stream (one-cycle pulses on `a`, same token format as halve_tokens) across N_OUT consumer lanes.
- Scheduling is weighted round-robin, with a runtime-programmable lane-enable mask and weight.
- Generalizes the fixed 1-of-2 token split into a configurable scheduler.
- Sits between a token source and several token consumers; configured by a control FSM over a valid/ready config port.

Parameters:
- N_OUT, 4, number of output lanes (2..16).
- W_W, 4, width of the weight field (tokens per lane before advancing).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  1  token strobe; each high cycle is one token.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config can be accepted this cycle.
- cfg_mask  input  N_OUT  lane enable mask; bit i enables lane i.
- cfg_weight  input  W_W  consecutive tokens per lane; 0 is treated as 1.
- b  output  N_OUT  dispatched token, at most one bit high per cycle.
- drop  output  1  pulses when a token arrives with no lane enabled.

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - b=0, drop=0.
  - Internal: mask=0, weight=1, ptr=0, cnt=0, state=IDLE.
  - cfg_ready is combinational and equals !a, including during reset.
- States:
  - IDLE: mask==0.
  - RUN: mask!=0.
  - Transitions happen only on config accept or reset.
- Config handshake:
  - Accepted on a rising edge where cfg_valid && cfg_ready, i.e. never in a token cycle.
  - On accept: mask<=cfg_mask; weight<=max(cfg_weight,1); ptr<=lowest set bit of cfg_mask (0 if none); cnt<=0.
  - State becomes RUN if cfg_mask!=0, else IDLE.
  - Takes effect for the first token after the accept edge.
  - cfg_valid held while a=1 stalls; no request is lost.
- Token dispatch, registered, latency 1 cycle:
  - a=1 in cycle t, state RUN: b==(1<<ptr) in cycle t+1, drop=0.
  - Then cnt increments. When cnt reaches weight-1: cnt<=0 and ptr<=next set mask bit above ptr, wrapping to the lowest set bit.
  - a=1 in cycle t, state IDLE: drop=1 in cycle t+1, b=0.
  - a=0: b=0, drop=0 next cycle.
- Back-to-back tokens (a high for many cycles) are each dispatched; no bubbles.
- Single enabled lane: all tokens go to that lane; ptr stays fixed.
- Weight arithmetic: cnt is W_W bits, compared against weight-1; no overflow possible.
- Reconfig mid-rotation discards the current cnt/ptr position; rotation restarts at the lowest enabled lane.
- Reset mid-operation: next cycle b=0, drop=0. Mask cleared, so subsequent tokens drop until reconfigured.
- Invariant: b is one-hot or zero; b and drop are never both nonzero.

Optional Feature:
- Macro TOKEN_DISPATCHER_STATS_EN.
- When defined:
  - Adds output port drop_cnt (16 bits): saturating count of drop pulses (holds at 16'hFFFF).
  - Adds input port stats_clr (1 bit): synchronous clear to 0. stats_clr takes priority over an increment in the same cycle.
  - Reset value of drop_cnt is 0.
- When undefined: neither port exists, and dispatch behaviour is identical.

Test Plan:
- Reset check: rst=1 for 5 cycles while a toggles every cycle -> b=0, drop=0 throughout; cfg_ready tracks !a.
- Plain round-robin: cfg_mask=4'b1111, cfg_weight=1, then a=1 for 8 consecutive cycles -> b sequence 0001,0010,0100,1000,0001,0010,0100,1000, each 1 cycle after its token.
- Sparse weighted: cfg_mask=4'b1010, cfg_weight=2, then 6 tokens spaced 15 time units apart -> b pulses on lanes 1,1,3,3,1,1. Repeat with cfg_weight=0 -> lanes 1,3,1,3,1,3.
- Handshake stall: cfg_valid=1 asserted in a cycle with a=1 -> no accept; accepted on the first a=0 cycle. Next token goes to the new mask's lowest lane.
- Drop path: cfg_mask=0, then 3 tokens -> drop high 3 single cycles, b=0. With TOKEN_DISPATCHER_STATS_EN: drop_cnt=3; stats_clr -> 0.
- Reset mid-operation: mask=4'b1111, 3 tokens, then rst for 1 cycle, then 2 tokens -> b=0 after reset; drop pulses twice.
